// File: rtl/lj_pair_scheduler.sv
// lj_pair_scheduler
// Streams one reference particle against its neighbor list into the LJ force
// pipeline. Neighbor records come from a 1-cycle-latency memory, and one pair
// is issued per cycle. Credits bound the number of pairs that are in flight or
// unpopped, so the downstream result FIFO cannot overflow. done pulses once all
// expected results of the job have returned.
//
// Optional build macro: LJ_SCHED_SKIP_SELF_EN. When it is defined, the slot
// whose address equals ref_index is consumed without a read, at most once per
// job.
//
// Timing, counted in cycles with the start pulse in cycle 0:
//   - The first read is issued in the same cycle that start is accepted, so
//     nb_rd_en is high in cycle 1 and pipe_ivalid is high in cycle 2.
//   - DONE lasts one cycle. done and the falling edge of busy both appear in
//     the cycle after DONE.
module lj_pair_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_WIDTH  = 13,   // must be at least ADDR_WIDTH+1
  parameter int FIFO_DEPTH = 32
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [4*DATA_WIDTH-1:0] ref_particle,
  input  logic [ADDR_WIDTH-1:0]   ref_index,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [CNT_WIDTH-1:0]    num_neighbors,
  output logic                    nb_rd_en,
  output logic [ADDR_WIDTH-1:0]   nb_rd_addr,
  input  logic [4*DATA_WIDTH-1:0] nb_rd_data,
  output logic                    pipe_ivalid,
  output logic [4*DATA_WIDTH-1:0] pipe_reference,
  output logic [4*DATA_WIDTH-1:0] pipe_neighbor,
  input  logic                    pipe_ovalid,
  input  logic                    res_pop,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_WIDTH-1:0]    outstanding
);

  localparam logic [CNT_WIDTH-1:0] CREDIT_LIMIT = CNT_WIDTH'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                  state_reg;
  logic [CNT_WIDTH-1:0]    issue_cnt_reg;
  logic [CNT_WIDTH-1:0]    res_cnt_reg;
  logic [CNT_WIDTH-1:0]    num_reg;
  logic [CNT_WIDTH-1:0]    outstanding_reg;
  logic [ADDR_WIDTH-1:0]   base_reg;
  logic [ADDR_WIDTH-1:0]   nb_rd_addr_reg;
  logic                    nb_rd_en_reg;
  logic                    pipe_ivalid_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic [4*DATA_WIDTH-1:0] pipe_reference_reg;
  logic                    skipped;

  // Job context: these come from the live inputs while a start is being
  // accepted in IDLE, and from the latched copies afterwards.
  logic [ADDR_WIDTH-1:0]   job_base;
  logic [CNT_WIDTH-1:0]    job_num;
  logic [CNT_WIDTH-1:0]    slot_cnt;

  logic                    accept_start;
  logic [ADDR_WIDTH-1:0]   slot_addr;
  logic                    slot_pending;
  logic                    self_hit;
  logic                    pop_eff;
  logic                    credit_ok;
  logic                    rd_fire;
  logic                    slot_done;
  logic                    slot_last;
  logic [CNT_WIDTH-1:0]    expected_cnt;
  logic                    res_inc;
  logic [CNT_WIDTH-1:0]    res_cnt_next;

`ifdef LJ_SCHED_SKIP_SELF_EN
  logic                    skipped_reg;
  logic [ADDR_WIDTH-1:0]   ref_idx_reg;
  logic [ADDR_WIDTH-1:0]   job_ref;
  logic                    job_skipped;
  assign skipped = skipped_reg;
`else
  // ref_index only matters when the self-skip build is enabled.
  logic unused_ref;
  assign unused_ref = ^ref_index;
  assign skipped    = 1'b0;
`endif

  // Select the job context: live inputs on an accepted start, latched values otherwise.
  always_comb begin
    job_base = base_reg;
    job_num  = num_reg;
    slot_cnt = issue_cnt_reg;
`ifdef LJ_SCHED_SKIP_SELF_EN
    job_ref     = ref_idx_reg;
    job_skipped = skipped_reg;
`endif
    if (state_reg == IDLE) begin
      job_base = base_addr;
      job_num  = num_neighbors;
      slot_cnt = '0;
`ifdef LJ_SCHED_SKIP_SELF_EN
      job_ref     = ref_index;
      job_skipped = 1'b0;
`endif
    end
  end

  assign accept_start = (state_reg == IDLE) && start;
  // The address wraps modulo 2^ADDR_WIDTH.
  assign slot_addr    = job_base + slot_cnt[ADDR_WIDTH-1:0];
  assign slot_pending = (accept_start || (state_reg == ISSUE)) && (slot_cnt < job_num);

`ifdef LJ_SCHED_SKIP_SELF_EN
  assign self_hit = slot_pending && !job_skipped && (slot_addr == job_ref);
`else
  assign self_hit = 1'b0;
`endif

  // A pop in the same cycle frees a credit, so a read can still go out when
  // the counter sits at the limit.
  assign pop_eff      = res_pop && (outstanding_reg != '0);
  assign credit_ok    = (outstanding_reg < CREDIT_LIMIT) || pop_eff;
  assign rd_fire      = slot_pending && !self_hit && credit_ok;
  assign slot_done    = rd_fire || self_hit;
  assign slot_last    = (slot_cnt + CNT_WIDTH'(1)) == job_num;

  assign expected_cnt = num_reg - CNT_WIDTH'(skipped);
  assign res_inc      = pipe_ovalid && (state_reg != IDLE) && (res_cnt_reg != expected_cnt);
  assign res_cnt_next = res_cnt_reg + CNT_WIDTH'(res_inc);

  // Control FSM with registered outputs, the credit counter and the result counter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg          <= IDLE;
      issue_cnt_reg      <= '0;
      res_cnt_reg        <= '0;
      num_reg            <= '0;
      outstanding_reg    <= '0;
      base_reg           <= '0;
      nb_rd_addr_reg     <= '0;
      nb_rd_en_reg       <= 1'b0;
      pipe_ivalid_reg    <= 1'b0;
      busy_reg           <= 1'b0;
      done_reg           <= 1'b0;
      pipe_reference_reg <= '0;
`ifdef LJ_SCHED_SKIP_SELF_EN
      skipped_reg        <= 1'b0;
      ref_idx_reg        <= '0;
`endif
    end else begin
      nb_rd_en_reg    <= rd_fire;
      pipe_ivalid_reg <= nb_rd_en_reg;
      done_reg        <= 1'b0;
      res_cnt_reg     <= res_cnt_next;
      if (rd_fire) begin
        nb_rd_addr_reg <= slot_addr;
      end

      // Credits are taken when the read is issued and returned when the
      // consumer pops an entry. A pop while the counter is already zero is
      // ignored.
      if (rd_fire && !pop_eff) begin
        outstanding_reg <= outstanding_reg + CNT_WIDTH'(1);
      end else if (!rd_fire && pop_eff) begin
        outstanding_reg <= outstanding_reg - CNT_WIDTH'(1);
      end

      case (state_reg)
        IDLE: begin
          if (start) begin
            base_reg           <= base_addr;
            num_reg            <= num_neighbors;
            pipe_reference_reg <= ref_particle;
            res_cnt_reg        <= '0;
            busy_reg           <= 1'b1;
            issue_cnt_reg      <= slot_done ? CNT_WIDTH'(1) : '0;
`ifdef LJ_SCHED_SKIP_SELF_EN
            ref_idx_reg        <= ref_index;
            skipped_reg        <= self_hit;
`endif
            if (num_neighbors == '0) begin
              state_reg <= DONE;
            end else if (slot_done && slot_last) begin
              state_reg <= DRAIN;
            end else begin
              state_reg <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (slot_done) begin
            issue_cnt_reg <= issue_cnt_reg + CNT_WIDTH'(1);
`ifdef LJ_SCHED_SKIP_SELF_EN
            if (self_hit) begin
              skipped_reg <= 1'b1;
            end
`endif
            if (slot_last) begin
              state_reg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Look ahead by one result, so that a result arriving in this cycle
          // is already counted.
          if (res_cnt_next == expected_cnt) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign nb_rd_en       = nb_rd_en_reg;
  assign nb_rd_addr     = nb_rd_addr_reg;
  assign pipe_ivalid    = pipe_ivalid_reg;
  assign pipe_reference = pipe_reference_reg;
  assign pipe_neighbor  = nb_rd_data;
  assign busy           = busy_reg;
  assign done           = done_reg;
  assign outstanding    = outstanding_reg;

endmodule

// File: tb/tb_lj_pair_scheduler.sv
// Directed testbench for lj_pair_scheduler.
// It models:
//   - a neighbor memory with 1-cycle read latency,
//   - a force pipeline with 24-cycle latency,
//   - a result consumer, which pops either automatically or under manual control.
// Outputs are sampled at the falling edge. Cycle numbers are counted relative
// to the start pulse.
module tb_lj_pair_scheduler;
  localparam int DW  = 32;
  localparam int AW  = 12;
  localparam int CW  = 13;
  localparam int FD  = 32;
  localparam int LAT = 24;

  localparam logic [4*DW-1:0] REF_A = 128'h0000_0000_3F80_0000_4000_0000_4040_0000;
  localparam logic [4*DW-1:0] REF_B = 128'h0000_0000_1111_1111_2222_2222_3333_3333;
  localparam logic [4*DW-1:0] REF_C = 128'h0000_0000_AAAA_0001_BBBB_0002_CCCC_0003;
  localparam logic [4*DW-1:0] REF_D = 128'h0000_0000_DDDD_DDDD_EEEE_EEEE_FFFF_FFFF;

  logic            clock = 1'b0;
  logic            resetn = 1'b1;
  logic            start = 1'b0;
  logic [4*DW-1:0] ref_particle = '0;
  logic [AW-1:0]   ref_index = '0;
  logic [AW-1:0]   base_addr = '0;
  logic [CW-1:0]   num_neighbors = '0;
  logic            nb_rd_en;
  logic [AW-1:0]   nb_rd_addr;
  logic [4*DW-1:0] nb_rd_data = '0;
  logic            pipe_ivalid;
  logic [4*DW-1:0] pipe_reference;
  logic [4*DW-1:0] pipe_neighbor;
  logic            pipe_ovalid;
  logic            res_pop;
  logic            busy;
  logic            done;
  logic [CW-1:0]   outstanding;

  always #5 clock = ~clock;

  lj_pair_scheduler #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .CNT_WIDTH  (CW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clock          (clock),
    .resetn         (resetn),
    .start          (start),
    .ref_particle   (ref_particle),
    .ref_index      (ref_index),
    .base_addr      (base_addr),
    .num_neighbors  (num_neighbors),
    .nb_rd_en       (nb_rd_en),
    .nb_rd_addr     (nb_rd_addr),
    .nb_rd_data     (nb_rd_data),
    .pipe_ivalid    (pipe_ivalid),
    .pipe_reference (pipe_reference),
    .pipe_neighbor  (pipe_neighbor),
    .pipe_ovalid    (pipe_ovalid),
    .res_pop        (res_pop),
    .busy           (busy),
    .done           (done),
    .outstanding    (outstanding)
  );

  // Environment: memory, fixed-latency pipeline, consumer
  logic [LAT-1:0] pipe_sr = '0;
  logic           ovalid_d = 1'b0;
  logic           auto_pop = 1'b0;
  logic           man_pop = 1'b0;
  int             cyc = 0;

  function automatic logic [4*DW-1:0] rec(input logic [AW-1:0] a);
    return {32'hA5A5_0000, 20'h00003, a, 20'h00002, a, 20'h00001, a};
  endfunction

  assign pipe_ovalid = pipe_sr[LAT-1];
  assign res_pop     = auto_pop ? ovalid_d : man_pop;

  always @(posedge clock) begin
    pipe_sr  <= {pipe_sr[LAT-2:0], pipe_ivalid};
    ovalid_d <= pipe_ovalid;
    if (nb_rd_en) nb_rd_data <= rec(nb_rd_addr);
    cyc <= cyc + 1;
  end

  // Monitor
  int            rd_cyc_q[$];
  logic [AW-1:0] rd_addr_q[$];
  int            iv_cyc_q[$];
  int            done_cyc_q[$];
  int            nb_err = 0;
  logic          last_en = 1'b0;
  logic [AW-1:0] last_addr = '0;

  always @(negedge clock) begin
    if (nb_rd_en) begin
      rd_cyc_q.push_back(cyc);
      rd_addr_q.push_back(nb_rd_addr);
    end
    if (pipe_ivalid) begin
      iv_cyc_q.push_back(cyc);
      if (!last_en || pipe_neighbor !== rec(last_addr)) nb_err++;
    end
    if (done) done_cyc_q.push_back(cyc);
    last_en   = nb_rd_en;
    last_addr = nb_rd_addr;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_mon();
    rd_cyc_q.delete();
    rd_addr_q.delete();
    iv_cyc_q.delete();
    done_cyc_q.delete();
    nb_err = 0;
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input logic [CW-1:0] n,
                             input logic [AW-1:0] ri, input logic [4*DW-1:0] rp,
                             output int s);
    base_addr     = b;
    num_neighbors = n;
    ref_index     = ri;
    ref_particle  = rp;
    start         = 1'b1;
    s             = cyc;
    tick();
    start         = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    for (int i = 0; i < limit && done_cyc_q.size() == 0; i++) tick();
    ok = (done_cyc_q.size() != 0);
  endtask

  function automatic int done_rel(input int s);
    return (done_cyc_q.size() != 0) ? done_cyc_q[0] - s : -1;
  endfunction

  function automatic int seq_errs(input logic [AW-1:0] b, input int s);
    int e = 0;
    for (int i = 0; i < rd_addr_q.size(); i++) begin
      logic [AW-1:0] ea;
      ea = b + AW'(i);
      if (rd_addr_q[i] !== ea || rd_cyc_q[i] - s != i + 1) e++;
    end
    return e;
  endfunction

  task automatic test_reset();
    resetn = 1'b1;
    #2;
    resetn = 1'b0;
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy); else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("FAIL reset_done: got %0b expected 0", done); else n_pass++;
    n_checks++;
    if (nb_rd_en !== 1'b0 || pipe_ivalid !== 1'b0)
      $display("FAIL reset_strobes: rd_en=%0b ivalid=%0b expected 0 0", nb_rd_en, pipe_ivalid);
    else n_pass++;
    n_checks++;
    if (nb_rd_addr !== '0 || pipe_reference !== '0 || outstanding !== '0)
      $display("FAIL reset_regs: addr=%0h ref=%0h outst=%0d expected all 0", nb_rd_addr, pipe_reference, outstanding);
    else n_pass++;
    resetn = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int s;
    bit ok;
    clear_mon();
    auto_pop = 1'b1;
    pulse_start(12'h010, 13'd5, 12'h7FF, REF_A, s);
    wait_done(100, ok);
    n_checks++;
    if (!ok) $display("FAIL basic_done_seen: got none expected pulse"); else n_pass++;
    n_checks++;
    if (done_rel(s) != 32) $display("FAIL basic_done_cycle: got %0d expected 32", done_rel(s)); else n_pass++;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL basic_done_busy: done=%0b busy=%0b expected 1 0", done, busy);
    else n_pass++;
    n_checks++;
    if (rd_addr_q.size() != 5 || seq_errs(12'h010, s) != 0)
      $display("FAIL basic_reads: count=%0d errs=%0d expected 5 0", rd_addr_q.size(), seq_errs(12'h010, s));
    else n_pass++;
    n_checks++;
    if (iv_cyc_q.size() != 5 || iv_cyc_q[0] - s != 2)
      $display("FAIL basic_ivalid: count=%0d first=%0d expected 5 2", iv_cyc_q.size(),
               (iv_cyc_q.size() != 0) ? iv_cyc_q[0] - s : -1);
    else n_pass++;
    n_checks++;
    if (nb_err != 0) $display("FAIL basic_neighbor_data: errors=%0d expected 0", nb_err); else n_pass++;
    n_checks++;
    if (pipe_reference !== REF_A) $display("FAIL basic_reference: got %0h expected %0h", pipe_reference, REF_A); else n_pass++;
    tick();
    n_checks++;
    if (done !== 1'b0) $display("FAIL basic_done_width: got %0b expected 0", done); else n_pass++;
    repeat (5) tick();
    n_checks++;
    if (outstanding !== '0) $display("FAIL basic_credits_returned: got %0d expected 0", outstanding); else n_pass++;
    $display("test_basic done: reads=%0d done_rel=%0d", rd_addr_q.size(), done_rel(s));
  endtask

  task automatic test_credit_stall();
    int s;
    int hold_err = 0;
    bit ok;
    clear_mon();
    auto_pop = 1'b0;
    man_pop  = 1'b0;
    pulse_start(12'h200, 13'd40, 12'h7FF, REF_B, s);
    repeat (44) tick();
    n_checks++;
    if (rd_addr_q.size() != 32 || outstanding !== 13'd32 || nb_rd_en !== 1'b0)
      $display("FAIL credit_stall: reads=%0d outst=%0d rd_en=%0b expected 32 32 0",
               rd_addr_q.size(), outstanding, nb_rd_en);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      man_pop = 1'b1;
      tick();
      if (outstanding !== 13'd32) hold_err++;
    end
    man_pop = 1'b0;
    tick();
    n_checks++;
    if (hold_err != 0) $display("FAIL credit_hold_at_limit: bad_cycles=%0d expected 0", hold_err); else n_pass++;
    n_checks++;
    if (rd_addr_q.size() != 40 || rd_cyc_q[32] - s != 46)
      $display("FAIL credit_refill: reads=%0d read33_rel=%0d expected 40 46", rd_addr_q.size(),
               (rd_cyc_q.size() > 32) ? rd_cyc_q[32] - s : -1);
    else n_pass++;
    wait_done(200, ok);
    n_checks++;
    if (!ok || done_rel(s) != 80) $display("FAIL credit_done: rel=%0d expected 80", done_rel(s)); else n_pass++;
    n_checks++;
    if (outstanding !== 13'd32) $display("FAIL credit_persist: got %0d expected 32", outstanding); else n_pass++;
    // Pop 32 times to drain, plus one extra pop that must be ignored at zero.
    man_pop = 1'b1;
    repeat (33) tick();
    man_pop = 1'b0;
    n_checks++;
    if (outstanding !== '0) $display("FAIL credit_saturate: got %0d expected 0", outstanding); else n_pass++;
    $display("test_credit_stall done: reads=%0d done_rel=%0d", rd_addr_q.size(), done_rel(s));
  endtask

  task automatic test_zero_wrap();
    int s;
    int errs = 0;
    bit ok;
    logic [AW-1:0] exp_a[4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    clear_mon();
    auto_pop = 1'b1;
    pulse_start(12'h123, 13'd0, 12'h7FF, REF_C, s);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL zero_busy_rel1: got %0b expected 1", busy); else n_pass++;
    tick();
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || rd_addr_q.size() != 0)
      $display("FAIL zero_done_rel2: done=%0b busy=%0b reads=%0d expected 1 0 0", done, busy, rd_addr_q.size());
    else n_pass++;
    repeat (2) tick();
    clear_mon();
    pulse_start(12'hFFE, 13'd4, 12'h7FF, REF_C, s);
    wait_done(100, ok);
    for (int i = 0; i < rd_addr_q.size() && i < 4; i++)
      if (rd_addr_q[i] !== exp_a[i]) errs++;
    n_checks++;
    if (rd_addr_q.size() != 4 || errs != 0)
      $display("FAIL wrap_addresses: count=%0d errs=%0d expected 4 0", rd_addr_q.size(), errs);
    else n_pass++;
    n_checks++;
    if (done_rel(s) != 31) $display("FAIL wrap_done_cycle: got %0d expected 31", done_rel(s)); else n_pass++;
    $display("test_zero_wrap done: reads=%0d done_rel=%0d", rd_addr_q.size(), done_rel(s));
  endtask

  task automatic test_start_while_busy();
    int s;
    bit ok;
    clear_mon();
    auto_pop = 1'b1;
    pulse_start(12'h300, 13'd6, 12'h7FF, REF_C, s);
    tick();
    base_addr     = 12'h500;
    num_neighbors = 13'd2;
    ref_particle  = REF_D;
    start         = 1'b1;
    tick();
    start         = 1'b0;
    wait_done(100, ok);
    n_checks++;
    if (rd_addr_q.size() != 6 || seq_errs(12'h300, s) != 0)
      $display("FAIL busy_start_reads: count=%0d errs=%0d expected 6 0", rd_addr_q.size(), seq_errs(12'h300, s));
    else n_pass++;
    n_checks++;
    if (pipe_reference !== REF_C) $display("FAIL busy_start_ref: got %0h expected %0h", pipe_reference, REF_C); else n_pass++;
    n_checks++;
    if (done_rel(s) != 33) $display("FAIL busy_start_done_cycle: got %0d expected 33", done_rel(s)); else n_pass++;
    repeat (40) tick();
    n_checks++;
    if (done_cyc_q.size() != 1 || rd_addr_q.size() != 6)
      $display("FAIL busy_start_no_second_job: dones=%0d reads=%0d expected 1 6", done_cyc_q.size(), rd_addr_q.size());
    else n_pass++;
    $display("test_start_while_busy done: reads=%0d", rd_addr_q.size());
  endtask

  task automatic test_reset_mid_job();
    int s;
    bit ok;
    clear_mon();
    auto_pop = 1'b0;
    pulse_start(12'h400, 13'd10, 12'h7FF, REF_B, s);
    tick();
    tick();
    resetn = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || nb_rd_en !== 1'b0 || outstanding !== '0 || pipe_ivalid !== 1'b0)
      $display("FAIL abort_outputs: busy=%0b rd_en=%0b outst=%0d ivalid=%0b expected 0 0 0 0",
               busy, nb_rd_en, outstanding, pipe_ivalid);
    else n_pass++;
    n_checks++;
    if (rd_addr_q.size() != 3) $display("FAIL abort_read_count: got %0d expected 3", rd_addr_q.size()); else n_pass++;
    tick();
    resetn = 1'b1;
    repeat (40) tick();
    n_checks++;
    if (done_cyc_q.size() != 0) $display("FAIL abort_no_done: got %0d expected 0", done_cyc_q.size()); else n_pass++;
    clear_mon();
    auto_pop = 1'b1;
    pulse_start(12'h010, 13'd3, 12'h7FF, REF_A, s);
    wait_done(100, ok);
    n_checks++;
    if (!ok || done_rel(s) != 30 || rd_addr_q.size() != 3 || seq_errs(12'h010, s) != 0)
      $display("FAIL abort_rerun: done_rel=%0d reads=%0d errs=%0d expected 30 3 0",
               done_rel(s), rd_addr_q.size(), seq_errs(12'h010, s));
    else n_pass++;
    $display("test_reset_mid_job done: rerun done_rel=%0d", done_rel(s));
  endtask

  task automatic test_self_skip();
    int s;
    int errs = 0;
    bit ok;
`ifdef LJ_SCHED_SKIP_SELF_EN
    int            n_exp = 3;
    logic [AW-1:0] exp_a[4] = '{12'h100, 12'h101, 12'h103, 12'h000};
    int            exp_c[4] = '{1, 2, 4, 0};
`else
    int            n_exp = 4;
    logic [AW-1:0] exp_a[4] = '{12'h100, 12'h101, 12'h102, 12'h103};
    int            exp_c[4] = '{1, 2, 3, 4};
`endif
    clear_mon();
    auto_pop = 1'b1;
    pulse_start(12'h100, 13'd4, 12'h102, REF_D, s);
    wait_done(100, ok);
    for (int i = 0; i < rd_addr_q.size() && i < 4; i++)
      if (rd_addr_q[i] !== exp_a[i] || rd_cyc_q[i] - s != exp_c[i]) errs++;
    n_checks++;
    if (rd_addr_q.size() != n_exp || errs != 0)
      $display("FAIL self_skip_reads: count=%0d errs=%0d expected %0d 0", rd_addr_q.size(), errs, n_exp);
    else n_pass++;
    n_checks++;
    if (!ok || done_rel(s) != 31) $display("FAIL self_skip_done: rel=%0d expected 31", done_rel(s)); else n_pass++;
    $display("test_self_skip done: reads=%0d done_rel=%0d", rd_addr_q.size(), done_rel(s));
  endtask

  initial begin
    test_reset();
    test_basic();
    test_credit_stall();
    test_zero_wrap();
    test_start_while_busy();
    test_reset_mid_job();
    test_self_skip();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
